// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM constants, slot index type and demux state enum
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int TDM_WIDTH = 8;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - TDM slot counter with clear/load-1/increment-wrap controls
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  load1,
  input  logic  inc,
  output slot_t slot,
  output logic  last
);

  assign last = (slot == slot_t'(NUM_SLOTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clear) begin
      slot <= '0;
    end else if (load1) begin
      slot <= slot_t'(1);
    end else if (inc) begin
      slot <= last ? '0 : slot + slot_t'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-channel TDM demultiplexer presenting frame-aligned outputs
// Optional parity checking is enabled with TDM_DEMUX_PARITY_EN.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             out_valid,
  output logic             locked,
  output logic             sync_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  input  logic             din_par,
  output logic             par_err
`endif
);

  state_t           state_q, state_d;
  slot_t            slot;
  logic             slot_last;
  logic             cnt_clear, cnt_load1, cnt_inc;
  logic [2:0]       stage_we;
  logic             out_load;
  logic             sync_err_d;
  logic [WIDTH-1:0] stage_q [3];

  tdm_slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .slot  (slot),
    .last  (slot_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_clear  = 1'b0;
    cnt_load1  = 1'b0;
    cnt_inc    = 1'b0;
    stage_we   = '0;
    out_load   = 1'b0;
    sync_err_d = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame) begin
            stage_we  = 3'b001;
            cnt_load1 = 1'b1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          // An early marker restarts the frame; the stale partial frame is overwritten.
          if (frame) begin
            stage_we   = 3'b001;
            cnt_load1  = 1'b1;
            sync_err_d = (slot != '0);
          end else if (slot == '0) begin
            sync_err_d = 1'b1;
            cnt_clear  = 1'b1;
            state_d    = HUNT;
          end else if (slot_last) begin
            out_load = 1'b1;
            cnt_inc  = 1'b1;
          end else begin
            stage_we = 3'b001 << slot;
            cnt_inc  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stage_we[i]) stage_q[i] <= din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      out_d     <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= out_load;
      sync_err  <= sync_err_d;
      if (out_load) begin
        out_a <= stage_q[0];
        out_b <= stage_q[1];
        out_c <= stage_q[2];
        out_d <= din;
      end
    end
  end

  assign locked = (state_q == LOCKED);

`ifdef TDM_DEMUX_PARITY_EN
  logic bad_q;
  logic par_mis;

  // din_par is even parity, so a clean sample has zero parity over {din, din_par}.
  assign par_mis = din_par ^ (^din);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q   <= 1'b0;
      par_err <= 1'b0;
    end else begin
      par_err <= out_load & (bad_q | par_mis);
      if (stage_we[0])                    bad_q <= par_mis;
      else if (stage_we[1] | stage_we[2]) bad_q <= bad_q | par_mis;
      else if (out_load)                  bad_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - scoreboard bench for tdm_demux4 with a queue-based frame model
module tb_tdm_demux4;

  localparam int W = 8;

  typedef struct packed {
    logic         locked;
    logic         sync;
    logic         valid;
    logic         par;
    logic [4*W-1:0] outs;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame = 1'b0;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic         out_valid, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic         din_par = 1'b0;
  logic         par_err;
`endif

  int checks = 0;
  int errors = 0;

  exp_t         exp_q[$];
  bit           m_locked;
  logic [W-1:0] m_frame[$];
  logic [W-1:0] m_out[4];
  bit           m_bad;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .frame     (frame),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .locked    (locked),
    .sync_err  (sync_err)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .din_par   (din_par),
    .par_err   (par_err)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_reset();
    exp_t e;
    m_locked = 1'b0;
    m_frame.delete();
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_bad = 1'b0;
    e = '0;
    return e;
  endfunction

  // Frame-level view: collect samples after a marker; four of them make a frame.
  function automatic exp_t model_step(input bit v, input bit f, input logic [W-1:0] d, input bit par_ok);
    exp_t e;
    e = '0;
    if (v) begin
      if (!m_locked) begin
        if (f) begin
          m_locked = 1'b1;
          m_frame.delete();
          m_frame.push_back(d);
          m_bad = !par_ok;
        end
      end else if (f) begin
        e.sync = (m_frame.size() != 0);
        m_frame.delete();
        m_frame.push_back(d);
        m_bad = !par_ok;
      end else if (m_frame.size() == 0) begin
        e.sync = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_frame.push_back(d);
        m_bad = m_bad | !par_ok;
        if (m_frame.size() == 4) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
          e.valid = 1'b1;
          e.par = m_bad;
          m_frame.delete();
        end
      end
    end
    e.locked = m_locked;
    e.outs = {m_out[0], m_out[1], m_out[2], m_out[3]};
    return e;
  endfunction

  task automatic cycle(input bit rst, input bit v, input bit f, input logic [W-1:0] d, input bit par_ok);
    bit was_run;
    @(negedge clk);
    was_run   = rst_n;
    rst_n     = rst;
    din_valid = v;
    frame     = f;
    din       = d;
`ifdef TDM_DEMUX_PARITY_EN
    din_par   = (^d) ^ !par_ok;
`endif
    if (!rst) exp_q.push_back(model_reset());
    else      exp_q.push_back(model_step(v, f, d, par_ok));
    if (!rst && was_run) begin
      #1;
      check("async_reset_outs", {out_a, out_b, out_c, out_d}, '0);
      check("async_reset_ctl", {out_valid, locked, sync_err}, 3'b000);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic send(input logic [W-1:0] d, input bit f);
    cycle(1'b1, 1'b1, f, d, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_valid", out_valid, e.valid);
        check("sync_err", sync_err, e.sync);
        check("locked", locked, e.locked);
        check("outs", {out_a, out_b, out_c, out_d}, e.outs);
`ifdef TDM_DEMUX_PARITY_EN
        check("par_err", par_err, e.par);
`endif
      end
    end
  end

  initial begin : stimulus
    int n;
    bit f;
    bit bad;
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // aligned frame
    send(8'h11, 1'b1); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    idle(2);
    // bubbles between slots 1 and 2
    send(8'h11, 1'b1); send(8'h22, 1'b0); idle(3); send(8'h33, 1'b0); send(8'h44, 1'b0);
    idle(1);
    // early marker
    send(8'h01, 1'b1); send(8'h02, 1'b0);
    send(8'hA0, 1'b1); send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
    idle(1);
    // missing marker, then non-frame samples while hunting
    send(8'h10, 1'b1); send(8'h11, 1'b0); send(8'h12, 1'b0); send(8'h13, 1'b0);
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0); idle(1);
    send(8'h81, 1'b1); send(8'h82, 1'b0); send(8'h83, 1'b0); send(8'h84, 1'b0);
    // reset mid-frame
    send(8'h91, 1'b1); send(8'h92, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h93, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    send(8'hC1, 1'b1); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
    idle(1);
`ifdef TDM_DEMUX_PARITY_EN
    send(8'hD1, 1'b1); send(8'hD2, 1'b0); cycle(1'b1, 1'b1, 1'b0, 8'hD3, 1'b0); send(8'hD4, 1'b0);
    send(8'hE1, 1'b1); send(8'hE2, 1'b0); send(8'hE3, 1'b0); send(8'hE4, 1'b0);
    idle(1);
`endif

    // random traffic: mostly well-formed frames with occasional framing faults
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        cycle(1'b1, 1'b0, ($urandom_range(0, 1) == 1), W'($urandom_range(0, 255)), 1'b1);
      end else begin
        if (m_frame.size() == 0) f = ($urandom_range(0, 15) != 0);
        else                     f = ($urandom_range(0, 15) == 0);
`ifdef TDM_DEMUX_PARITY_EN
        bad = ($urandom_range(0, 19) == 0);
`else
        bad = 1'b0;
`endif
        if ($urandom_range(0, 499) == 0) cycle(1'b0, 1'b1, f, W'($urandom_range(0, 255)), 1'b1);
        else cycle(1'b1, 1'b1, f, W'($urandom_range(0, 255)), !bad);
      end
    end
    idle(2);

    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
